// File: rtl/harmonic_note_player.sv
// harmonic_note_player: sample engine for one music-player voice.
// A 22-bit phase accumulator runs at the latched note's pitch. Each codec request yields one
// signed 16-bit sample two cycles later. A free-running beat tick is also produced.
// Build option: define HARMONIC_MIX_EN to add 2nd/3rd harmonic lookups and weight-selected
// mixing. Without it only the fundamental lookup exists and weight is ignored.
module harmonic_note_player #(
    parameter int unsigned BEAT_WIDTH = 17,
    parameter int unsigned BEAT_STOP  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_enable,
    input  logic [5:0]  note_to_load,
    input  logic        load_new_note,
    input  logic [1:0]  weight,
    input  logic        generate_next_sample,
    output logic [15:0] harmonic_out,
    output logic        harmonic_ready,
    output logic        beat
);

    localparam longint ONE_Q30 = 64'sd1073741824;
    localparam longint PI_Q30  = 64'sd3373259426;
    localparam longint LN2_Q30 = 64'sd744261118;
    localparam logic [BEAT_WIDTH-1:0] BEAT_LAST = BEAT_WIDTH'(BEAT_STOP - 1);

    // round(32767*sin(pi*k/512)) for k in 0..256, Q30 Taylor series in Horner form
    function automatic logic [15:0] quarter_sine(input int unsigned k);
        longint x, x2, t, s;
        x  = (PI_Q30 * longint'(k)) / 64'sd512;
        x2 = (x * x) >>> 30;
        t  = ONE_Q30;
        for (int unsigned i = 6; i >= 1; i--) begin
            t = ONE_Q30 - ((x2 * t) >>> 30) / longint'(2 * i * (2 * i + 1));
        end
        s = (x * t) >>> 30;
        return 16'((s * 64'sd32767 + (ONE_Q30 >>> 1)) >>> 30);
    endfunction

    // round(55*2^((n-1)/12) * 2^22 / 48000), note 0 is a rest with zero step
    function automatic logic [21:0] note_step(input int unsigned n);
        longint      y, e, term, num;
        int unsigned m, oct, semi;
        if (n == 0) begin
            return '0;
        end
        m    = n - 1;
        oct  = m / 12;
        semi = m % 12;
        y    = (LN2_Q30 * longint'(semi)) / 64'sd12;
        e    = ONE_Q30;
        term = ONE_Q30;
        for (int unsigned i = 1; i <= 12; i++) begin
            term = ((term * y) >>> 30) / longint'(i);
            e    = e + term;
        end
        num = (e * 64'sd55) <<< oct;
        return 22'((num + 64'sd6144000) / 64'sd12288000);
    endfunction

    logic [15:0] quarter  [257];
    logic [21:0] step_tab [64];

    for (genvar k = 0; k < 257; k++) begin : g_quarter
        assign quarter[k] = quarter_sine(k);
    end

    for (genvar n = 0; n < 64; n++) begin : g_step
        assign step_tab[n] = note_step(n);
    end

    // Full-cycle sine from the quarter wave: quadrant 1/3 mirror the index, 2/3 negate.
    function automatic logic signed [15:0] sine_at(input logic [9:0] a);
        logic [15:0] mag;
        mag = a[8] ? quarter[9'd256 - {1'b0, a[7:0]}] : quarter[{1'b0, a[7:0]}];
        return a[9] ? -$signed(mag) : $signed(mag);
    endfunction

    logic [5:0]            note_q, note_d;
    logic [21:0]           phase_q, phase_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_play_q, s1_play_d;
    logic signed [15:0]    f1_q, f1_d;
    logic signed [15:0]    out_q, out_d;
    logic signed [15:0]    mix;
    logic                  ready_q, ready_d;
    logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  beat_q, beat_d;

`ifdef HARMONIC_MIX_EN
    logic signed [15:0] f2_q, f2_d;
    logic signed [15:0] f3_q, f3_d;
    logic [9:0]         addr3;
    logic [11:0]        unused_p3_lsb;

    // 3*p1 mod 2^22; only the top ten bits address the lookup
    assign {addr3, unused_p3_lsb} = phase_q + {phase_q[20:0], 1'b0};
`else
    logic unused_weight;

    assign unused_weight = ^weight;
`endif

    // Phase accumulator and stage 1 (table read); load wins over advance
    always_comb begin
        note_d     = note_q;
        phase_d    = phase_q;
        if (load_new_note) begin
            note_d  = note_to_load;
            phase_d = '0;
        end else if (generate_next_sample && play_enable) begin
            phase_d = phase_q + step_tab[note_q];
        end
        s1_valid_d = generate_next_sample;
        s1_play_d  = generate_next_sample ? play_enable : s1_play_q;
        f1_d       = generate_next_sample ? sine_at(phase_q[21:12]) : f1_q;
`ifdef HARMONIC_MIX_EN
        f2_d       = generate_next_sample ? sine_at(phase_q[20:11]) : f2_q;
        f3_d       = generate_next_sample ? sine_at(addr3) : f3_q;
`endif
    end

    // Stage 2: weight-selected mix, silenced when the request arrived while paused
    always_comb begin
`ifdef HARMONIC_MIX_EN
        unique case (weight)
            2'd0:    mix = f1_q;
            2'd1:    mix = (f1_q >>> 1) + (f2_q >>> 2) + (f3_q >>> 2);
            2'd2:    mix = (f1_q >>> 2) + (f2_q >>> 1) + (f3_q >>> 2);
            default: mix = (f1_q >>> 2) + (f2_q >>> 2) + (f3_q >>> 1);
        endcase
`else
        mix = f1_q;
`endif
        out_d   = out_q;
        if (s1_valid_q) begin
            out_d = s1_play_q ? mix : '0;
        end
        ready_d = s1_valid_q;
    end

    // Free-running beat counter; beat_q marks the cycle the count sits at its last value
    always_comb begin
        beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BEAT_WIDTH'(1);
        beat_d     = (beat_cnt_d == BEAT_LAST);
    end

    // State registers, all cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_q     <= '0;
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_play_q  <= 1'b0;
            f1_q       <= '0;
`ifdef HARMONIC_MIX_EN
            f2_q       <= '0;
            f3_q       <= '0;
`endif
            out_q      <= '0;
            ready_q    <= 1'b0;
            beat_cnt_q <= '0;
            beat_q     <= 1'b0;
        end else begin
            note_q     <= note_d;
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_play_q  <= s1_play_d;
            f1_q       <= f1_d;
`ifdef HARMONIC_MIX_EN
            f2_q       <= f2_d;
            f3_q       <= f3_d;
`endif
            out_q      <= out_d;
            ready_q    <= ready_d;
            beat_cnt_q <= beat_cnt_d;
            beat_q     <= beat_d;
        end
    end

    assign harmonic_out   = out_q;
    assign harmonic_ready = ready_q;
    assign beat           = beat_q;

endmodule

// File: tb/tb_harmonic_note_player.sv
// Testbench for harmonic_note_player: scoreboard of expected samples, sine from $sin.
module tb_harmonic_note_player;

    localparam int MASK22 = 32'h003F_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic [5:0]  note_to_load;
    logic        load_new_note;
    logic [1:0]  weight;
    logic        generate_next_sample;
    logic [15:0] harmonic_out;
    logic        harmonic_ready;
    logic        beat;

    harmonic_note_player #(
        .BEAT_WIDTH(17),
        .BEAT_STOP (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .play_enable         (play_enable),
        .note_to_load        (note_to_load),
        .load_new_note       (load_new_note),
        .weight              (weight),
        .generate_next_sample(generate_next_sample),
        .harmonic_out        (harmonic_out),
        .harmonic_ready      (harmonic_ready),
        .beat                (beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f1;
        int f2;
        int f3;
        bit play;
        int due;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_no  = 0;
    int   m_phase  = 0;
    int   m_note   = 0;
    int   m_cnt    = 0;
    int   m_out    = 0;
    int   m_tol    = 0;

    function automatic int bsine(input int a);
        real v;
        v = 32767.0 * $sin(2.0 * 3.141592653589793 * a / 1024.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int bstep(input int n);
        case (n)
            1:       return 4806;
            22:      return 16165;
            default: return 0;
        endcase
    endfunction

    function automatic int bmix(input ent_t e, input logic [1:0] w);
`ifdef HARMONIC_MIX_EN
        case (w)
            2'd0:    return e.f1;
            2'd1:    return (e.f1 >>> 1) + (e.f2 >>> 2) + (e.f3 >>> 2);
            2'd2:    return (e.f1 >>> 2) + (e.f2 >>> 1) + (e.f3 >>> 2);
            default: return (e.f1 >>> 2) + (e.f2 >>> 2) + (e.f3 >>> 1);
        endcase
`else
        return e.f1;
`endif
    endfunction

    // One clock: drive at negedge, update the model, check just after the rising edge.
    task automatic tick(input string tag, input bit gen, input bit play, input bit load,
                        input logic [5:0] note, input logic [1:0] w);
        ent_t e;
        int   got, diff;
        bit   exp_rdy, exp_beat;
        generate_next_sample = gen;
        play_enable          = play;
        load_new_note        = load;
        note_to_load         = note;
        weight               = w;
        if (gen) begin
            e.f1   = bsine(m_phase >> 12);
            e.f2   = bsine(((2 * m_phase) & MASK22) >> 12);
            e.f3   = bsine(((3 * m_phase) & MASK22) >> 12);
            e.play = play;
            e.due  = edge_no + 2;
            sb.push_back(e);
        end
        if (load) begin
            m_phase = 0;
            m_note  = note;
        end else if (gen && play) begin
            m_phase = (m_phase + bstep(m_note)) & MASK22;
        end
        @(posedge clk);
        #1;
        edge_no++;
        m_cnt    = (m_cnt == 4) ? 0 : m_cnt + 1;
        exp_beat = (m_cnt == 4);
        exp_rdy  = 1'b0;
        if (sb.size() > 0 && sb[0].due == edge_no) begin
            e       = sb.pop_front();
            exp_rdy = 1'b1;
            m_out   = e.play ? bmix(e, w) : 0;
            m_tol   = (m_out == 0) ? 0 : ((w == 2'd0) ? 1 : 2);
        end
        n_checks++;
        if (harmonic_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s ready @edge %0d: got %0b, expected %0b", tag, edge_no, harmonic_ready, exp_rdy);
        end
        got  = int'($signed(harmonic_out));
        diff = got - m_out;
        n_checks++;
        if ($isunknown(harmonic_out) || diff > m_tol || diff < -m_tol) begin
            n_fail++;
            $display("FAIL %s out @edge %0d: got %0d, expected %0d (+/-%0d)", tag, edge_no, got, m_out, m_tol);
        end
        n_checks++;
        if (beat !== exp_beat) begin
            n_fail++;
            $display("FAIL %s beat @edge %0d: got %0b, expected %0b", tag, edge_no, beat, exp_beat);
        end
        @(negedge clk);
    endtask

    // Assert reset at a low clock phase, check outputs clear at once, release two edges later.
    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        n_checks++;
        if (harmonic_out !== 16'd0 || harmonic_ready !== 1'b0 || beat !== 1'b0) begin
            n_fail++;
            $display("FAIL %s async clear: got out=%0d ready=%0b beat=%0b, expected 0/0/0",
                     tag, $signed(harmonic_out), harmonic_ready, beat);
        end
        sb.delete();
        m_phase = 0;
        m_note  = 0;
        m_cnt   = 0;
        m_out   = 0;
        m_tol   = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (harmonic_out !== 16'd0 || harmonic_ready !== 1'b0 || beat !== 1'b0) begin
            n_fail++;
            $display("FAIL %s held in reset: got out=%0d ready=%0b beat=%0b, expected 0/0/0",
                     tag, $signed(harmonic_out), harmonic_ready, beat);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        apply_reset("reset");
        for (int i = 0; i < 12; i++) tick("reset_idle", 1'b0, 1'b0, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic test_fundamental();
        tick("fund_load", 1'b0, 1'b1, 1'b1, 6'd1, 2'd0);
        for (int i = 0; i < 14; i++) tick("fund", 1'b1, 1'b1, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic test_weights();
        for (int w = 1; w < 4; w++) begin
            for (int i = 0; i < 10; i++) begin
                tick("weight", 1'b1, 1'b1, 1'b0, 6'd0, 2'(w));
                n_checks++;
                if (harmonic_out === 16'h8000) begin
                    n_fail++;
                    $display("FAIL weight_range: got %0d, expected |out| <= 32767", $signed(harmonic_out));
                end
            end
        end
        tick("weight_drain", 1'b0, 1'b1, 1'b0, 6'd0, 2'd1);
        tick("weight_drain", 1'b0, 1'b1, 1'b0, 6'd0, 2'd1);
    endtask

    task automatic test_pause();
        for (int i = 0; i < 6; i++) tick("pause", 1'b1, 1'b0, 1'b0, 6'd0, 2'd1);
        for (int i = 0; i < 3; i++) tick("pause_idle", 1'b0, 1'b0, 1'b0, 6'd0, 2'd1);
        for (int i = 0; i < 8; i++) tick("resume", 1'b1, 1'b1, 1'b0, 6'd0, 2'd1);
    endtask

    task automatic test_load_paused();
        tick("load22", 1'b0, 1'b0, 1'b1, 6'd22, 2'd0);
        tick("load22_req_paused", 1'b1, 1'b0, 1'b0, 6'd0, 2'd0);
        for (int i = 0; i < 10; i++) tick("note22", 1'b1, 1'b1, 1'b0, 6'd0, 2'(i % 4));
        tick("load_rest", 1'b0, 1'b1, 1'b1, 6'd0, 2'd0);
        for (int i = 0; i < 6; i++) tick("rest", 1'b1, 1'b1, 1'b0, 6'd0, 2'($urandom_range(0, 3)));
    endtask

    task automatic test_back_to_back();
        tick("b2b_load", 1'b0, 1'b1, 1'b1, 6'd22, 2'd0);
        for (int i = 0; i < 30; i++)
            tick("b2b", 1'($urandom_range(0, 1)), 1'b1, 1'b0, 6'd0, 2'($urandom_range(0, 3)));
        tick("b2b_drain", 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
        tick("b2b_drain", 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic test_reset_midstream();
        tick("mid_load", 1'b0, 1'b1, 1'b1, 6'd1, 2'd0);
        for (int i = 0; i < 6; i++) tick("mid_run", 1'b1, 1'b1, 1'b0, 6'd0, 2'd0);
        apply_reset("mid_reset");
        for (int i = 0; i < 3; i++) tick("post_reset_idle", 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
        tick("post_reset_load", 1'b0, 1'b1, 1'b1, 6'd1, 2'd0);
        tick("post_reset_req", 1'b1, 1'b1, 1'b0, 6'd0, 2'd0);
        tick("post_reset_req", 1'b1, 1'b1, 1'b0, 6'd0, 2'd0);
        for (int i = 0; i < 3; i++) tick("post_reset_drain", 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        reset                = 1'b1;
        play_enable          = 1'b0;
        note_to_load         = 6'd0;
        load_new_note        = 1'b0;
        weight               = 2'd0;
        generate_next_sample = 1'b0;
        test_reset();
        test_fundamental();
        test_weights();
        test_pause();
        test_load_paused();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
